// File: rtl/fp_pkg.sv
// Shared float format for the multiply/accumulate path: field widths, special
// encodings, field unpacking and the accumulator FSM states.
package fp_pkg;

    localparam int FP_EXPONENT = 8;
    localparam int FP_MANTISSA = 8;
    localparam int FP_WIDTH    = FP_EXPONENT + FP_MANTISSA + 1;
    localparam int FP_BIAS     = 2 ** (FP_EXPONENT - 1) - 1;

    localparam logic [FP_WIDTH-1:0] FP_NAN =
        {1'b1, {FP_EXPONENT{1'b1}}, 1'b1, {(FP_MANTISSA-1){1'b0}}};
    localparam logic [FP_WIDTH-1:0] FP_POS_INF =
        {1'b0, {FP_EXPONENT{1'b1}}, {FP_MANTISSA{1'b0}}};
    localparam logic [FP_WIDTH-1:0] FP_NEG_INF =
        {1'b1, {FP_EXPONENT{1'b1}}, {FP_MANTISSA{1'b0}}};

    typedef enum logic [1:0] {
        ST_ACCEPT = 2'd0,
        ST_ALIGN  = 2'd1,
        ST_NORM   = 2'd2,
        ST_EMIT   = 2'd3
    } state_t;

    typedef struct packed {
        logic                   sign;
        logic [FP_EXPONENT-1:0] exp;
        logic [FP_MANTISSA-1:0] frac;
        logic                   is_zero;
        logic                   is_inf;
        logic                   is_nan;
    } fp_fields_t;

    // A zero exponent means zero: denormal fractions are flushed here.
    function automatic fp_fields_t fp_unpack(input logic [FP_WIDTH-1:0] w);
        fp_fields_t f;
        f.sign    = w[FP_WIDTH-1];
        f.exp     = w[FP_WIDTH-2 -: FP_EXPONENT];
        f.frac    = w[FP_MANTISSA-1:0];
        f.is_zero = (f.exp == '0);
        f.is_inf  = (f.exp == '1) && (f.frac == '0);
        f.is_nan  = (f.exp == '1) && (f.frac != '0);
        return f;
    endfunction

endpackage

// File: rtl/fp_lzc.sv
// Leading-zero counter; all-zero input returns W. Purely combinational.
module fp_lzc #(
    parameter int W  = 13,
    parameter int CW = $clog2(W + 1)
) (
    input  logic [W-1:0]  i_vec,
    output logic [CW-1:0] o_cnt
);

    always_comb begin
        o_cnt = CW'(W);
        for (int i = 0; i < W; i++) begin
            if (i_vec[i]) o_cnt = CW'(W - 1 - i);
        end
    end

endmodule

// File: rtl/fp_accumulator.sv
// Sequential float sum per last-terminated group; one term per 3 cycles, sum valid 3 edges after last.
// in_ready drops outside ACCEPT; a pending sum holds until out_ready.
module fp_accumulator import fp_pkg::*; #(
    parameter int EXPONENT = FP_EXPONENT,
    parameter int MANTISSA = FP_MANTISSA,
    parameter int WIDTH    = EXPONENT + MANTISSA + 1,
    parameter int GUARD    = 3,
    parameter int COUNT_W  = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [COUNT_W-1:0] out_count
);

    localparam int SW  = MANTISSA + GUARD + 2;
    localparam int LZW = $clog2(SW + 1);

    state_t               r_state;
    logic [WIDTH-1:0]     r_acc;
    logic [WIDTH-1:0]     r_opnd;
    logic                 r_last;
    logic [COUNT_W-1:0]   r_count;
    logic                 r_out_valid;
    logic [WIDTH-1:0]     r_out_data;
    logic [COUNT_W-1:0]   r_out_count;

    logic [SW-1:0]        r_big_mant;
    logic [SW-1:0]        r_sml_mant;
    logic [EXPONENT-1:0]  r_big_exp;
    logic                 r_sign;
    logic                 r_sub;
    logic                 r_nan;
    logic                 r_inf;
    logic                 r_inf_sign;

    fp_fields_t w_a;
    fp_fields_t w_b;
    assign w_a = fp_unpack(r_acc);
    assign w_b = fp_unpack(r_opnd);

    logic [EXPONENT+MANTISSA-1:0] w_key_a;
    logic [EXPONENT+MANTISSA-1:0] w_key_b;
    logic                         w_a_big;
    assign w_key_a = w_a.is_zero ? '0 : {w_a.exp, w_a.frac};
    assign w_key_b = w_b.is_zero ? '0 : {w_b.exp, w_b.frac};
    assign w_a_big = (w_key_a >= w_key_b);

    logic                w_big_sign, w_big_zero, w_sml_zero;
    logic [EXPONENT-1:0] w_big_exp, w_sml_exp, w_diff, w_shamt;
    logic [MANTISSA-1:0] w_big_frac, w_sml_frac;
    logic [SW-1:0]       w_big_mant, w_sml_mant, w_sml_aligned;

    assign w_big_sign = w_a_big ? w_a.sign    : w_b.sign;
    assign w_big_zero = w_a_big ? w_a.is_zero : w_b.is_zero;
    assign w_big_exp  = w_a_big ? w_a.exp     : w_b.exp;
    assign w_big_frac = w_a_big ? w_a.frac    : w_b.frac;
    assign w_sml_zero = w_a_big ? w_b.is_zero : w_a.is_zero;
    assign w_sml_exp  = w_a_big ? w_b.exp     : w_a.exp;
    assign w_sml_frac = w_a_big ? w_b.frac    : w_a.frac;

    // Top bit of each mantissa is headroom for the carry-out of the add.
    assign w_big_mant = w_big_zero ? '0 : {1'b0, 1'b1, w_big_frac, {GUARD{1'b0}}};
    assign w_sml_mant = w_sml_zero ? '0 : {1'b0, 1'b1, w_sml_frac, {GUARD{1'b0}}};
    assign w_diff        = w_big_exp - w_sml_exp;
    assign w_shamt       = (w_diff >= EXPONENT'(SW)) ? EXPONENT'(SW) : w_diff;
    assign w_sml_aligned = w_sml_mant >> w_shamt;

    logic [SW-1:0]              w_sum;
    logic [LZW-1:0]             w_lzc;
    logic [SW-1:0]              w_norm;
    logic [MANTISSA-1:0]        w_frac;
    logic signed [EXPONENT+1:0] w_exp_n;
    logic [WIDTH-1:0]           w_result;

    assign w_sum = r_sub ? (r_big_mant - r_sml_mant) : (r_big_mant + r_sml_mant);

    fp_lzc #(.W(SW), .CW(LZW)) u_lzc (
        .i_vec (w_sum),
        .o_cnt (w_lzc)
    );

    // Shifting the leading one up to the carry position covers both the
    // carry-out (lzc=0, exponent+1) and the cancellation cases in one formula.
    assign w_norm  = w_sum << w_lzc;
    assign w_frac  = MANTISSA'(w_norm >> (GUARD + 1));
    assign w_exp_n = {2'b00, r_big_exp} + (EXPONENT+2)'(1) - (EXPONENT+2)'(w_lzc);

    always_comb begin
        w_result = {r_sign, w_exp_n[EXPONENT-1:0], w_frac};
        if (r_nan)
            w_result = FP_NAN;
        else if (r_inf)
            w_result = r_inf_sign ? FP_NEG_INF : FP_POS_INF;
        else if (w_sum == '0)
            w_result = '0;
        else if (w_exp_n >= $signed({2'b00, {EXPONENT{1'b1}}}))
            w_result = r_sign ? FP_NEG_INF : FP_POS_INF;
        else if (w_exp_n <= $signed((EXPONENT+2)'(0)))
            w_result = '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_ACCEPT;
            r_acc       <= '0;
            r_opnd      <= '0;
            r_last      <= 1'b0;
            r_count     <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_count <= '0;
            r_big_mant  <= '0;
            r_sml_mant  <= '0;
            r_big_exp   <= '0;
            r_sign      <= 1'b0;
            r_sub       <= 1'b0;
            r_nan       <= 1'b0;
            r_inf       <= 1'b0;
            r_inf_sign  <= 1'b0;
        end else begin
            case (r_state)
                ST_ACCEPT: begin
                    if (in_valid && in_ready) begin
                        r_opnd  <= in_data;
                        r_last  <= in_last;
                        r_count <= (r_count == '1) ? r_count : r_count + COUNT_W'(1);
                        r_state <= ST_ALIGN;
                    end
                end
                ST_ALIGN: begin
                    r_big_mant <= w_big_mant;
                    r_sml_mant <= w_sml_aligned;
                    r_big_exp  <= w_big_exp;
                    r_sign     <= w_big_sign;
                    r_sub      <= w_a.sign ^ w_b.sign;
                    r_nan      <= w_a.is_nan || w_b.is_nan ||
                                  (w_a.is_inf && w_b.is_inf && (w_a.sign != w_b.sign));
                    r_inf      <= w_a.is_inf || w_b.is_inf;
                    r_inf_sign <= w_a.is_inf ? w_a.sign : w_b.sign;
                    r_state    <= ST_NORM;
                end
                ST_NORM: begin
                    r_acc   <= w_result;
                    r_state <= r_last ? ST_EMIT : ST_ACCEPT;
                end
                ST_EMIT: begin
                    if (!r_out_valid) begin
                        r_out_valid <= 1'b1;
                        r_out_data  <= r_acc;
                        r_out_count <= r_count;
                    end else if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_acc       <= '0;
                        r_count     <= '0;
                        r_state     <= ST_ACCEPT;
                    end
                end
                default: r_state <= ST_ACCEPT;
            endcase
        end
    end

    assign in_ready  = (r_state == ST_ACCEPT) && !reset;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_count = r_out_count;

endmodule

// File: tb/tb_fp_accumulator.sv
// Directed bench for fp_accumulator: expected group sums are queued at the
// last term and popped when the sum is presented.
module tb_fp_accumulator;

    localparam int WIDTH   = 17;
    localparam int COUNT_W = 16;

    logic               clk = 1'b0;
    logic               reset;
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   in_data;
    logic               in_last;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   out_data;
    logic [COUNT_W-1:0] out_count;

    typedef struct {
        logic [WIDTH-1:0]   data;
        logic [COUNT_W-1:0] count;
    } exp_t;

    exp_t sb[$];
    int   checks      = 0;
    int   errors      = 0;
    int   group_terms = 0;

    fp_accumulator dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_count (out_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $error("FAIL watchdog: observed no finish, expected finish before 200000");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    // Present one term, wait for the handshake, then scramble the bus.
    task automatic send(input logic [WIDTH-1:0] d, input logic last, input logic [WIDTH-1:0] exp_sum);
        int n = 0;
        while (!in_ready && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check("in_ready_wait", 32'(in_ready), 32'd1);
        if (in_ready) begin
            in_valid = 1'b1;
            in_data  = d;
            in_last  = last;
            @(posedge clk); #1;
            in_valid = 1'b0;
            in_data  = WIDTH'($urandom);
            in_last  = 1'($urandom_range(0, 1));
            group_terms++;
            if (last) begin
                sb.push_back('{exp_sum, COUNT_W'(group_terms)});
                group_terms = 0;
            end
        end
    endtask

    task automatic recv(input string tag);
        exp_t e;
        int   n = 0;
        while (!out_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_sb"}, 32'(sb.size() > 0), 32'd1);
        if (out_valid && sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, "_data"}, 32'(out_data), 32'(e.data));
            check({tag, "_count"}, 32'(out_count), 32'(e.count));
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
            check({tag, "_drop"}, 32'(out_valid), 32'd0);
        end
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready",  32'(in_ready),  32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data",  32'(out_data),  32'd0);
        check("rst_out_count", 32'(out_count), 32'd0);
        reset = 1'b0;
        #1;
        check("idle_in_ready", 32'(in_ready), 32'd1);

        // 1.0 + 2.0 = 3.0 with exact output latency
        send(17'h07F00, 1'b0, 17'h0);
        send(17'h08000, 1'b1, 17'h08080);
        for (int i = 1; i <= 3; i++) begin
            @(posedge clk); #1;
            check("latency", 32'(out_valid), 32'(i == 3));
        end
        recv("sum_1_2");

        send(17'h07F80, 1'b0, 17'h0);
        send(17'h17F00, 1'b0, 17'h0);
        send(17'h17E00, 1'b1, 17'h00000);
        recv("cancel");

        send(17'h0FEFF, 1'b0, 17'h0);
        send(17'h0FEFF, 1'b1, 17'h0FF00);
        recv("overflow");

        send(17'h0FF00, 1'b0, 17'h0);
        send(17'h1FF00, 1'b1, 17'h1FF80);
        recv("inf_minus_inf");

        send(17'h0FF01, 1'b0, 17'h0);
        send(17'h07F00, 1'b1, 17'h1FF80);
        recv("nan_sticky");

        send(17'h0FF01, 1'b1, 17'h1FF80);
        recv("nan_canon");

        send(17'h00055, 1'b1, 17'h00000);
        recv("denormal");

        send(17'h07F00, 1'b0, 17'h0);
        send(17'h00F00, 1'b1, 17'h07F00);
        recv("shift_sat");

        send(17'h07F00, 1'b0, 17'h0);
        send(17'h07701, 1'b1, 17'h07F01);
        recv("lsb_kept");

        send(17'h07F00, 1'b0, 17'h0);
        send(17'h07601, 1'b1, 17'h07F00);
        recv("guard_trunc");

        send(17'h07F00, 1'b0, 17'h0);
        send(17'h1FF00, 1'b1, 17'h1FF00);
        recv("neg_inf");

        send(17'h08080, 1'b0, 17'h0);
        send(17'h17F00, 1'b1, 17'h08000);
        recv("sub_norm");

        // Consumer stalls while a new term is offered
        send(17'h07F00, 1'b1, 17'h07F00);
        for (int n = 0; n < 40 && !out_valid; n++) begin
            @(posedge clk); #1;
        end
        in_valid = 1'b1;
        in_data  = 17'h0FF00;
        in_last  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("hold_in_ready",  32'(in_ready),  32'd0);
            check("hold_out_valid", 32'(out_valid), 32'd1);
            check("hold_out_data",  32'(out_data),  32'h07F00);
        end
        in_valid = 1'b0;
        recv("hold");
        send(17'h08000, 1'b1, 17'h08000);
        recv("after_hold");

        // Reset while the second term of a group is in ALIGN
        send(17'h07F00, 1'b0, 17'h0);
        send(17'h08000, 1'b0, 17'h0);
        reset = 1'b1;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_out_data",  32'(out_data),  32'd0);
        check("midrst_out_count", 32'(out_count), 32'd0);
        check("midrst_in_ready",  32'(in_ready),  32'd0);
        group_terms = 0;
        @(posedge clk); #1;
        reset = 1'b0;
        send(17'h08000, 1'b1, 17'h08000);
        recv("post_reset");

        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fp_accumulator.md
Name: fp_accumulator

Overview:
- Sequential floating-point sum reducer placed directly downstream of the combinational multiplier.
- Consumes a stream of products over a valid/ready handshake. Each group ends with a `last` flag.
- Produces one summed result per group over a valid/ready handshake.
- Uses the same packed format (sign, biased exponent, hidden-one mantissa), flush-to-zero and truncation rules as the multiplier, so a dot product is the multiplier followed by this block.

Parameters:
EXPONENT, 8, exponent field width; bias = 2^(EXPONENT-1)-1
MANTISSA, 8, stored fraction width (hidden one not stored)
WIDTH, EXPONENT+MANTISSA+1, packed word width
GUARD, 3, extra low-order bits kept through alignment and subtraction
COUNT_W, 16, width of the term counter

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  asynchronous, active-high; clears all state
in_valid  in  1  product word presented
in_ready  out  1  block accepts a term this cycle
in_data  in  WIDTH  product (sign, exponent, fraction)
in_last  in  1  qualifies in_data as final term of group
out_valid  out  1  group sum available
out_ready  in  1  consumer accepts sum
out_data  out  WIDTH  accumulated sum
out_count  out  COUNT_W  terms summed in this group; saturates at all-ones

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-high.
- Reset values: state=ACCEPT, acc=+0, count=0, out_valid=0, out_data=0, out_count=0. in_ready=0 while reset is high.
- FSM states: ACCEPT, ALIGN, NORM, EMIT.
- ACCEPT:
  - in_ready=1.
  - On in_valid&in_ready: register operand and in_last, increment count (saturating), go to ALIGN.
- ALIGN:
  - Unpack acc and operand. Exponent==0 means zero (flush; fraction ignored).
  - Order by magnitude (exponent, then fraction).
  - Right-shift the smaller {1,frac,GUARD zeros} by the exponent difference. The shift saturates at MANTISSA+GUARD+2, giving a zero contribution.
  - Register the aligned pair and special flags. Go to NORM.
- NORM:
  - Add when signs are equal, else subtract smaller from larger. The result sign is the larger operand's sign.
  - Normalise: on carry-out, right-shift 1 and exponent+1. Otherwise left-shift by leading-zero count and exponent-lzc.
  - Truncate the guard bits (no rounding).
  - Write acc. Go to EMIT if the registered last flag is set, else ACCEPT.
- EMIT:
  - out_valid=1; out_data=acc and out_count=count, both stable while waiting.
  - On out_ready: clear acc to +0 and count to 0, go to ACCEPT.
  - in_ready=0 in EMIT, ALIGN and NORM.
- Timing:
  - Throughput is one term per 3 cycles.
  - Handshake at edge k gives out_valid high after edge k+3 when last.
  - out_valid may stay high indefinitely; there is no timeout.
- Arithmetic special cases (priority order):
  - Any NaN input, or inf+(-inf) → canonical NaN {1, all-ones exp, 1, zeros}. NaN is sticky for the rest of the group.
  - Otherwise any inf → inf with that sign.
  - Exact cancellation → +0.
  - Normalised exponent ≥ all-ones → inf of result sign.
  - Normalised exponent ≤ 0 → +0 (flush).
  - Zero operand → other operand passes through, with denormals flushed to +0.
- Single-term group: output equals the input, with denormals flushed to +0 and NaN canonicalised.
- Reset mid-operation: FSM returns to ACCEPT immediately. The in-flight term and partial sum are discarded; out_valid drops asynchronously.
- in_data and in_last are sampled only at handshake. Changes at other times are ignored.

Decomposition:
- Shared package fp_pkg:
  - EXPONENT/MANTISSA defaults and BIAS.
  - Canonical NaN/+inf/-inf constants.
  - Unpack function returning sign, exponent, fraction, is_zero, is_inf, is_nan.
  - FSM state enum.
- Sub-module fp_lzc: parameterised leading-zero counter over MANTISSA+GUARD+2 bits, used in NORM.

Test Plan (EXPONENT=8, MANTISSA=8):
- 1.0 (0x07F00) then 2.0 (0x08000, last) → out_data 0x08080 (3.0), out_count 2, out_valid exactly 3 cycles after the second handshake.
- 1.5 (0x07F80), -1.0 (0x17F00), -0.5 (0x17E00, last) → 0x00000 (+0), count 3.
- 0x0FEFF + 0x0FEFF (last) → 0x0FF00 (+inf). Separately, +inf (0x0FF00) + -inf (0x1FF00) → 0x1FF80 (NaN); a NaN followed by 1.0 also → 0x1FF80.
- Denormal 0x00055 alone with last → 0x00000. 1.0 + 0x00F00 (exponent 15, shift ≥ saturation) → 0x07F00.
- Hold out_ready=0 for 10 cycles with in_valid=1 → in_ready stays 0 and out_data stays stable; after out_ready the next group starts from +0 with count restarting at 1.
- Assert reset in ALIGN of the second term of a group → outputs clear immediately; a new group 2.0 (last) after release → 0x08000, count 1.
